argmax_stream: RTL and testbench



---
 rtl/argmax_stream.sv | 77 +++++++
 tb/tb_argmax_stream.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/argmax_stream.sv
// Streaming argmax over M signed words per vector; holds the winning index and value for output.
// Define ARGMAX_TIE_LAST_EN to let the highest index win on equal maxima (default: lowest wins).
module argmax_stream #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned M     = 8,
  localparam int unsigned IDXW = (M > 1) ? $clog2(M) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             input_valid,
  output logic             input_ready,
  input  logic [WIDTH-1:0] input_data,
  output logic             output_valid,
  input  logic             output_ready,
  output logic [IDXW-1:0]  output_index,
  output logic [WIDTH-1:0] output_max
);

  typedef enum logic {StAcc, StDone} state_e;

  state_e           r_state;
  logic [IDXW-1:0]  r_cnt;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_max;

  logic w_better;
  logic w_last;

`ifdef ARGMAX_TIE_LAST_EN
  assign w_better = $signed(input_data) >= $signed(r_max);
`else
  assign w_better = $signed(input_data) > $signed(r_max);
`endif

  assign w_last = (r_cnt == IDXW'(M - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StAcc;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_max   <= '0;
    end else begin
      unique case (r_state)
        StAcc: begin
          if (input_valid) begin
            // Element 0 always reloads so nothing carries over from the previous vector.
            if (r_cnt == '0) begin
              r_max <= input_data;
              r_idx <= '0;
            end else if (w_better) begin
              r_max <= input_data;
              r_idx <= r_cnt;
            end
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= StDone;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        StDone: begin
          if (output_ready) r_state <= StAcc;
        end
        default: r_state <= StAcc;
      endcase
    end
  end

  // Ready is held low while reset is asserted, and rises as soon as it is released.
  assign input_ready  = (r_state == StAcc) && !reset;
  assign output_valid = (r_state == StDone);
  assign output_index = r_idx;
  assign output_max   = r_max;

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream: an M=8 instance for the main cases and an M=1 instance.
module tb_argmax_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        input_valid;
  logic        input_ready;
  logic [15:0] input_data;
  logic        output_valid;
  logic        output_ready;
  logic [2:0]  output_index;
  logic [15:0] output_max;

  logic        u1_valid;
  logic        u1_ready;
  logic [15:0] u1_data;
  logic        u1_out_valid;
  logic        u1_out_ready;
  logic [0:0]  u1_index;
  logic [15:0] u1_max;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  argmax_stream #(.WIDTH(16), .M(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_index (output_index),
    .output_max   (output_max)
  );

  argmax_stream #(.WIDTH(16), .M(1)) dut_m1 (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (u1_valid),
    .input_ready  (u1_ready),
    .input_data   (u1_data),
    .output_valid (u1_out_valid),
    .output_ready (u1_out_ready),
    .output_index (u1_index),
    .output_max   (u1_max)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one word for one cycle; returns #1 after the accepting edge.
  task automatic drive_word(input logic [15:0] d);
    input_valid = 1'b1;
    input_data  = d;
    @(posedge clk);
    #1;
    input_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [15:0] v [8], input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(max_gap, 0)) idle_cycle();
      drive_word(v[i]);
    end
  endtask

  task automatic check_result(input string tag, input logic [2:0] idx, input logic [15:0] mx);
    check({tag, "_valid"}, output_valid, 1'b1);
    check({tag, "_index"}, output_index, idx);
    check({tag, "_max"}, output_max, mx);
    check({tag, "_rdy"}, input_ready, 1'b0);
  endtask

  logic [15:0] v_mix [8] = '{16'h0003, 16'hFFFB, 16'h0064, 16'h0007,
                             16'h0064, 16'h8000, 16'h7FFF, 16'h0000};
  logic [15:0] v_tie [8] = '{16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5};
  logic [15:0] v_up  [8] = '{16'hFFF8, 16'hFFF9, 16'hFFFA, 16'hFFFB,
                             16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF};
  logic [15:0] v_dn  [8] = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC,
                             16'hFFFB, 16'hFFFA, 16'hFFF9, 16'hFFF8};
  logic [15:0] v_bp  [8] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
  logic [15:0] v_m3  [8] = '{16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFD,
                             16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFE};
  logic [15:0] v_nine[8] = '{16'd9, 16'd9, 16'd9, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0};
  logic [15:0] v_ramp[8] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'hFFFF};
  logic [15:0] v_one [3] = '{16'd42, 16'hFFF9, 16'h8000};

  initial begin
    reset        = 1'b1;
    input_valid  = 1'b0;
    input_data   = '0;
    output_ready = 1'b1;
    u1_valid     = 1'b0;
    u1_data      = '0;
    u1_out_ready = 1'b1;

    repeat (2) idle_cycle();
    check("rst_rdy", input_ready, 1'b0);
    check("rst_valid", output_valid, 1'b0);
    check("rst_index", output_index, 3'd0);
    check("rst_max", output_max, 16'd0);
    check("rst_m1_rdy", u1_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("post_rst_rdy", input_ready, 1'b1);

    // Mixed vector back-to-back
    send_vec(v_mix, 7, 0);
    check("mix_pre_valid", output_valid, 1'b0);
    drive_word(v_mix[7]);
    check_result("mix", 3'd6, 16'h7FFF);
    idle_cycle();
    check("mix_back_rdy", input_ready, 1'b1);
    check("mix_back_valid", output_valid, 1'b0);

    // Ties
    send_vec(v_tie, 8, 0);
`ifdef ARGMAX_TIE_LAST_EN
    check_result("tie", 3'd7, 16'd5);
`else
    check_result("tie", 3'd0, 16'd5);
`endif
    idle_cycle();

    // All negative with gaps, then reversed to confirm no carry-over
    send_vec(v_up, 8, 2);
    check_result("neg_up", 3'd7, 16'hFFFF);
    idle_cycle();
    send_vec(v_dn, 8, 2);
    check_result("neg_dn", 3'd0, 16'hFFFF);
    idle_cycle();

    // Backpressure: driven words must be ignored while the result is held
    output_ready = 1'b0;
    send_vec(v_bp, 8, 0);
    check_result("bp_first", 3'd7, 16'd8);
    input_valid = 1'b1;
    input_data  = 16'h7FFF;
    for (int i = 0; i < 10; i++) begin
      idle_cycle();
      check_result("bp_hold", 3'd7, 16'd8);
    end
    input_valid  = 1'b0;
    output_ready = 1'b1;
    idle_cycle();
    check("bp_rel_valid", output_valid, 1'b0);
    check("bp_rel_rdy", input_ready, 1'b1);
    send_vec(v_m3, 8, 0);
    check_result("bp_next", 3'd7, 16'hFFFE);
    idle_cycle();

    // Reset mid-vector
    send_vec(v_nine, 4, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_rdy", input_ready, 1'b0);
    check("mid_rst_valid", output_valid, 1'b0);
    check("mid_rst_index", output_index, 3'd0);
    check("mid_rst_max", output_max, 16'd0);
    idle_cycle();
    reset = 1'b0;
    #1;
    send_vec(v_ramp, 8, 0);
    check_result("ramp", 3'd6, 16'd6);
    idle_cycle();

    // M=1 instance: one result every two cycles with input_valid held high
    u1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      u1_data = v_one[k];
      idle_cycle();
      check("m1_valid", u1_out_valid, 1'b1);
      check("m1_index", u1_index, 1'b0);
      check("m1_max", u1_max, v_one[k]);
      check("m1_rdy_done", u1_ready, 1'b0);
      u1_data = 16'h1234;
      idle_cycle();
      check("m1_rdy_acc", u1_ready, 1'b1);
      check("m1_valid_acc", u1_out_valid, 1'b0);
    end
    u1_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
